// File: rtl/regfile_2r1w_pkg.sv
// Shared constants and types for the 2-read / 1-write register file.
// Index width and the zero-register encoding live here so later pipeline stages agree on them.
package regfile_2r1w_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Read-port bundle reserved for operand forwarding in a later pipeline stage.
    typedef struct packed {
        reg_idx_t    idx;
        logic [31:0] data;
    } rd_port_t;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Write/read bus of the register file.
// The datapath side is the master; the register file is the slave.
interface regfile_2r1w_if #(
    parameter int DATA_WIDTH = 32
);
    import regfile_2r1w_pkg::*;

    logic                  ctrl_writeEnable;
    reg_idx_t              ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic                  read_req;
    reg_idx_t              ctrl_readRegA;
    reg_idx_t              ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  read_valid;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output read_req, ctrl_readRegA, ctrl_readRegB,
        input  data_readRegA, data_readRegB, read_valid
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  read_req, ctrl_readRegA, ctrl_readRegB,
        output data_readRegA, data_readRegB, read_valid
    );

endinterface

// File: rtl/regfile_2r1w_reg_word.sv
// One storage word of the register file: load-enabled flop with asynchronous active-low clear.
module regfile_2r1w_reg_word #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x DATA_WIDTH register file, two registered read ports, one write port, r0 hardwired to zero.
// BYPASS_EN selects whether a same-edge write to the read index is forwarded to the read data.
module regfile_2r1w
    import regfile_2r1w_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS_EN  = 1
) (
    input  logic           clock,
    input  logic           reset,
    regfile_2r1w_if.slave  rf
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:1]  wr_sel;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic                  byp_a;
    logic                  byp_b;
    logic [DATA_WIDTH-1:0] rd_a_q;
    logic [DATA_WIDTH-1:0] rd_b_q;
    logic                  valid_q;

    // One-hot write decode; r0 has no storage so its select line is simply absent.
    always_comb begin
        wr_sel = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            wr_sel[i] = rf.ctrl_writeEnable && (rf.ctrl_writeReg == REG_IDX_W'(i));
        end
    end

    assign regs[0] = '0;

    for (genvar g = 1; g < REG_COUNT; g++) begin : g_word
        regfile_2r1w_reg_word #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_word (
            .clock (clock),
            .reset (reset),
            .we    (wr_sel[g]),
            .d     (rf.data_writeReg),
            .q     (regs[g])
        );
    end

    // A write aimed at r0 never forwards, so bypass is qualified by a non-zero index.
    assign byp_a = (BYPASS_EN != 0) && rf.ctrl_writeEnable
                   && (rf.ctrl_writeReg == rf.ctrl_readRegA) && (rf.ctrl_readRegA != ZERO_REG);
    assign byp_b = (BYPASS_EN != 0) && rf.ctrl_writeEnable
                   && (rf.ctrl_writeReg == rf.ctrl_readRegB) && (rf.ctrl_readRegB != ZERO_REG);

    always_comb begin
        sel_a = regs[rf.ctrl_readRegA];
        sel_b = regs[rf.ctrl_readRegB];
        if (rf.ctrl_readRegA == ZERO_REG) begin
            sel_a = '0;
        end else if (byp_a) begin
            sel_a = rf.data_writeReg;
        end
        if (rf.ctrl_readRegB == ZERO_REG) begin
            sel_b = '0;
        end else if (byp_b) begin
            sel_b = rf.data_writeReg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rf.read_req;
            if (rf.read_req) begin
                rd_a_q <= sel_a;
                rd_b_q <= sel_b;
            end
        end
    end

    assign rf.data_readRegA = rd_a_q;
    assign rf.data_readRegB = rd_b_q;
    assign rf.read_valid    = valid_q;

endmodule
